demux_tdm: RTL and testbench
============================

DEMUX_TDM -- requirements
Module: demux_tdm

Interface
REQ-001 SHALL provide parameter: WIDTH, default 1, bits per channel slot within one frame.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL provide port: din  input  1  serial TDM data bit, MSB of each slot first.
REQ-005 SHALL provide port: in_valid  input  1  din/sync qualified this cycle; low means stall.
REQ-006 SHALL provide port: sync  input  1  marks the first bit of a frame (slot a, bit WIDTH-1).
REQ-007 SHALL provide ports: a, b, c, d  output  WIDTH each  demultiplexed channel words for slots 0..3, registered.
REQ-008 SHALL provide ports: s1, s2  output  1 each  slot index of the next expected bit; s1 is the MSB (00=a, 01=b, 10=c, 11=d).
REQ-009 SHALL provide port: frame_valid  output  1  one-cycle pulse when a..d are updated with a new frame.
REQ-010 SHALL provide port: sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-011 SHALL implement a two-state FSM: HUNT and RECV.
REQ-012 In HUNT, bits with in_valid=1 and sync=0 SHALL be discarded without error, and s1s2 SHALL read 00.
REQ-013 In HUNT, in_valid=1 with sync=1 SHALL accept din as bit WIDTH-1 of slot 0 and move to RECV.
REQ-014 In RECV, each in_valid=1 cycle SHALL shift din into the slot shift register and advance a bit counter (WIDTH-1 down to 0) and a 2-bit slot counter.
REQ-015 A cycle with in_valid=0 SHALL leave all counters, shift registers, outputs and state unchanged; frame_valid and sync_err SHALL be 0.
REQ-016 On acceptance of the last bit of a slot, the assembled WIDTH-bit word SHALL be written to that slot's shadow register.
REQ-017 On acceptance of the last bit of slot 3, the slot counter SHALL wrap to 0, the bit counter SHALL reload, and on the next rising edge a..d SHALL load all four shadows simultaneously with frame_valid=1 for exactly one cycle.
REQ-018 Latency SHALL be exactly one clock from the edge that accepts the final frame bit to frame_valid=1 with the new a..d.
REQ-019 a..d SHALL hold their values between frame_valid pulses; partial frames SHALL never reach a..d.
REQ-020 In RECV at a frame boundary (slot 0, first bit), in_valid=1 with sync=1 SHALL be accepted normally as bit WIDTH-1 of slot 0 (back-to-back frames, no idle cycle required).
REQ-021 In RECV at a frame boundary, in_valid=1 with sync=0 SHALL pulse sync_err, discard the bit, and move to HUNT.
REQ-022 In RECV mid-frame, in_valid=1 with sync=1 SHALL pulse sync_err, discard the partial frame, and accept this bit as bit WIDTH-1 of slot 0 of a new frame, staying in RECV.
REQ-023 If the final bit of a frame and a frame_valid update coincide with a new sync bit on the following cycle, both SHALL take effect; the new frame's first bit SHALL not be lost.
REQ-024 s1s2 SHALL update on the same edge as the slot counter.

Reset
REQ-025 rst=1 SHALL force HUNT, clear all counters, shift and shadow registers, and set a..d=0, s1=0, s2=0, frame_valid=0, sync_err=0 on the next edge.
REQ-026 rst SHALL take priority over in_valid; reset mid-frame SHALL discard the partial frame without a frame_valid or sync_err pulse.

Verification
REQ-027 SHALL cover basic frame: WIDTH=1, stream (sync on first) 0,0,0,1 -> a=0 b=0 c=0 d=1, frame_valid high one cycle after the 4th bit.
REQ-028 SHALL cover stalls: WIDTH=1, bits 1,0,1,1 with in_valid=0 gaps between them -> a=1 b=0 c=1 d=1, one frame_valid pulse, s1s2 steps 00->01->10->11->00.
REQ-029 SHALL cover back-to-back frames: WIDTH=2, frames 0x1B (a=00 b=01 c=10 d=11) then a=11 b=10 c=01 d=00 with no gap -> two frame_valid pulses exactly 8 accepted bits apart, correct values each.
REQ-030 SHALL cover early sync: WIDTH=1, sync raised on the 3rd bit -> sync_err one cycle, a..d unchanged, the next 4 bits decode as a fresh frame.
REQ-031 SHALL cover a missing sync: the bit after a complete frame arrives with sync=0 -> sync_err pulse, HUNT, no frame_valid until the next sync.
REQ-032 SHALL cover reset mid-frame: rst asserted after 2 of 4 bits -> a..d=0, s1s2=00, no pulses, next sync frame decodes correctly.

Source files
------------

// File: rtl/demux_tdm.sv
// demux_tdm: serial TDM demultiplexer, four channel slots per frame.
//
// Bits arrive MSB first on din, qualified by in_valid. A sync bit marks the
// first bit of slot 0. Each completed slot is parked in a shadow register;
// once slot 3 completes, all four shadows are copied to a..d together on the
// following edge, with a one-cycle frame_valid pulse.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   din          serial data bit
//   in_valid     din/sync qualifier; low stalls the receiver
//   sync         first bit of a frame (slot 0, bit WIDTH-1)
//   a, b, c, d   registered channel words for slots 0..3
//   s1, s2       slot index of the next expected bit (s1 = MSB)
//   frame_valid  one-cycle pulse when a..d take a new frame
//   sync_err     one-cycle pulse on a framing violation
module demux_tdm #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s2,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic {StHunt, StRecv} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_q, bit_d;
  logic [1:0]             slot_q, slot_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [WIDTH-1:0]       shadow_q [4];
  logic [WIDTH-1:0]       shadow_d [4];
  logic                   load_q, load_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                   fv_q, fv_d;
  logic                   err_q, err_d;

  logic                   boundary;
  logic                   accept;
  logic                   start;
  logic [CntW-1:0]        cur_bit;
  logic [1:0]             cur_slot;
  logic [WIDTH-1:0]       cur_shift;
  logic [WIDTH-1:0]       word;

  assign boundary = (slot_q == 2'd0) && (bit_q == LastBit);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    slot_d   = slot_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    load_d   = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
    start    = 1'b0;

    // Output load is tied to the edge after the final bit, independent of
    // in_valid, so latency to frame_valid is always exactly one clock.
    if (load_q) begin
      a_d  = shadow_q[0];
      b_d  = shadow_q[1];
      c_d  = shadow_q[2];
      d_d  = shadow_q[3];
      fv_d = 1'b1;
    end

    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            accept  = 1'b1;
            start   = 1'b1;
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (boundary) begin
            if (sync) begin
              accept = 1'b1;
              start  = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = StHunt;
            end
          end else begin
            accept = 1'b1;
            // Early sync: drop the partial frame, restart on this bit.
            if (sync) begin
              err_d = 1'b1;
              start = 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    cur_bit   = start ? LastBit : bit_q;
    cur_slot  = start ? 2'd0 : slot_q;
    cur_shift = start ? '0 : shift_q;
    word      = (cur_shift << 1) | WIDTH'(din);

    if (accept) begin
      if (cur_bit == '0) begin
        shadow_d[cur_slot] = word;
        bit_d              = LastBit;
        slot_d             = cur_slot + 2'd1;
        shift_d            = '0;
        if (cur_slot == 2'd3) begin
          load_d = 1'b1;
        end
      end else begin
        bit_d   = cur_bit - CntW'(1);
        slot_d  = cur_slot;
        shift_d = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      bit_q    <= LastBit;
      slot_q   <= 2'd0;
      shift_q  <= '0;
      shadow_q <= '{default: '0};
      load_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      load_q   <= load_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign s1          = slot_q[1];
  assign s2          = slot_q[0];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_demux_tdm.sv
// Bench for demux_tdm: one WIDTH=1 and one WIDTH=2 instance, directed
// scenarios followed by biased random traffic, checked every cycle against
// a bit-counting frame model.
module tb_demux_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=1
  logic       rst0 = 1'b0, iv0 = 1'b0, sy0 = 1'b0, dn0 = 1'b0;
  logic [0:0] a0, b0, c0, d0;
  logic       s1_0, s2_0, fv0, er0;
  // Instance 1: WIDTH=2
  logic       rst1 = 1'b0, iv1 = 1'b0, sy1 = 1'b0, dn1 = 1'b0;
  logic [1:0] a1, b1, c1, d1;
  logic       s1_1, s2_1, fv1, er1;

  demux_tdm #(.WIDTH(1)) dut0 (
    .clk(clk), .rst(rst0), .din(dn0), .in_valid(iv0), .sync(sy0),
    .a(a0), .b(b0), .c(c0), .d(d0), .s1(s1_0), .s2(s2_0),
    .frame_valid(fv0), .sync_err(er0)
  );

  demux_tdm #(.WIDTH(2)) dut1 (
    .clk(clk), .rst(rst1), .din(dn1), .in_valid(iv1), .sync(sy1),
    .a(a1), .b(b1), .c(c1), .d(d1), .s1(s1_1), .s2(s2_1),
    .frame_valid(fv1), .sync_err(er1)
  );

  // Observed values widened to 2 bits for uniform comparison.
  logic [1:0] ow [2][4];
  logic [1:0] os [2];
  logic       ofv [2];
  logic       oer [2];
  assign ow[0][0] = {1'b0, a0};
  assign ow[0][1] = {1'b0, b0};
  assign ow[0][2] = {1'b0, c0};
  assign ow[0][3] = {1'b0, d0};
  assign ow[1][0] = a1;
  assign ow[1][1] = b1;
  assign ow[1][2] = c1;
  assign ow[1][3] = d1;
  assign os[0]    = {s1_0, s2_0};
  assign os[1]    = {s1_1, s2_1};
  assign ofv[0]   = fv0;
  assign ofv[1]   = fv1;
  assign oer[0]   = er0;
  assign oer[1]   = er1;

  // Reference model: a frame is 4*W accepted bits; slot = bits so far / W.
  int         wd [2] = '{1, 2};
  bit         in_frame [2];
  int         n [2];
  logic       fb [2][8];
  bit         pend [2];
  logic [1:0] pw [2][4];
  logic [1:0] ea [2][4];
  bit         efv [2];
  bit         eerr [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic add_bit(input int i, input logic bv);
    logic [1:0] w;
    fb[i][n[i]] = bv;
    n[i]++;
    if (n[i] == 4 * wd[i]) begin
      for (int k = 0; k < 4; k++) begin
        w = 2'd0;
        for (int j = 0; j < wd[i]; j++) w = (w << 1) | {1'b0, fb[i][k * wd[i] + j]};
        pw[i][k] = w;
      end
      pend[i] = 1'b1;
      n[i]    = 0;
    end
  endtask

  task automatic model_upd(input int i, input logic r, input logic iv, input logic sy,
                           input logic bv);
    efv[i]  = 1'b0;
    eerr[i] = 1'b0;
    if (r) begin
      in_frame[i] = 1'b0;
      n[i]        = 0;
      pend[i]     = 1'b0;
      for (int k = 0; k < 4; k++) ea[i][k] = 2'd0;
      return;
    end
    if (pend[i]) begin
      for (int k = 0; k < 4; k++) ea[i][k] = pw[i][k];
      efv[i]  = 1'b1;
      pend[i] = 1'b0;
    end
    if (iv) begin
      if (!in_frame[i]) begin
        if (sy) begin
          in_frame[i] = 1'b1;
          n[i]        = 0;
          add_bit(i, bv);
        end
      end else if (n[i] == 0) begin
        if (sy) add_bit(i, bv);
        else begin
          eerr[i]     = 1'b1;
          in_frame[i] = 1'b0;
        end
      end else if (sy) begin
        eerr[i] = 1'b1;
        n[i]    = 0;
        add_bit(i, bv);
      end else begin
        add_bit(i, bv);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    string nm [4] = '{"a", "b", "c", "d"};
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) chk($sformatf("dut%0d_%s", i, nm[k]), ow[i][k], ea[i][k]);
      chk($sformatf("dut%0d_slot", i), os[i], 2'(n[i] / wd[i]));
      chk($sformatf("dut%0d_frame_valid", i), {1'b0, ofv[i]}, {1'b0, efv[i]});
      chk($sformatf("dut%0d_sync_err", i), {1'b0, oer[i]}, {1'b0, eerr[i]});
    end
  endtask

  // sel 0/1 drives that instance and idles the other; sel 2 drives both.
  task automatic step(input int sel, input bit r, input bit iv, input bit sy, input bit dn);
    rst0 = (sel != 1) ? r  : 1'b0;
    iv0  = (sel != 1) ? iv : 1'b0;
    sy0  = (sel != 1) ? sy : 1'b0;
    dn0  = (sel != 1) ? dn : 1'b0;
    rst1 = (sel != 0) ? r  : 1'b0;
    iv1  = (sel != 0) ? iv : 1'b0;
    sy1  = (sel != 0) ? sy : 1'b0;
    dn1  = (sel != 0) ? dn : 1'b0;
    @(posedge clk);
    model_upd(0, rst0, iv0, sy0, dn0);
    model_upd(1, rst1, iv1, sy1, dn1);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int  sel;
    bit  r, iv, sy, dn;

    // Reset state
    step(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_a0", ow[0][0], 2'd0);
    chk("reset_slot1", os[1], 2'd0);
    idle(1);

    // Basic frame, WIDTH=1: 0,0,0,1
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk("basic_fv_not_yet", {1'b0, ofv[0]}, 2'd0);
    idle(1);
    chk("basic_d", ow[0][3], 2'd1);
    chk("basic_fv", {1'b0, ofv[0]}, 2'd1);

    // Stalls between bits: 1,0,1,1
    step(0, 0, 1, 1, 1); idle(1);
    step(0, 0, 1, 0, 0); idle(2);
    step(0, 0, 1, 0, 1); idle(1);
    chk("stall_slot", os[0], 2'd3);
    step(0, 0, 1, 0, 1); idle(1);
    chk("stall_a", ow[0][0], 2'd1);
    chk("stall_b", ow[0][1], 2'd0);
    chk("stall_slot_wrap", os[0], 2'd0);
    idle(1);

    // Back-to-back WIDTH=2 frames: 00 01 10 11 then 11 10 01 00
    begin
      bit f1 [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
      bit f2 [8] = '{1, 1, 1, 0, 0, 1, 0, 0};
      for (int k = 0; k < 8; k++) step(1, 0, 1, k == 0, f1[k]);
      for (int k = 0; k < 8; k++) begin
        step(1, 0, 1, k == 0, f2[k]);
        if (k == 0) begin
          chk("b2b_fv1", {1'b0, ofv[1]}, 2'd1);
          chk("b2b_d1", ow[1][3], 2'd3);
        end
      end
      idle(1);
      chk("b2b_fv2", {1'b0, ofv[1]}, 2'd1);
      chk("b2b_a2", ow[1][0], 2'd3);
      chk("b2b_d2", ow[1][3], 2'd0);
    end

    // Early sync on the third bit, WIDTH=1
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1);
    chk("early_err", {1'b0, oer[0]}, 2'd1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    idle(1);
    chk("early_fresh_c", ow[0][2], 2'd1);

    // Missing sync after a complete frame
    step(0, 0, 1, 0, 1);
    chk("miss_err", {1'b0, oer[0]}, 2'd1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk("hunt_slot", os[0], 2'd0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    idle(1);
    chk("resync_a", ow[0][0], 2'd1);

    // Reset mid-frame
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("midrst_a", ow[0][0], 2'd0);
    chk("midrst_slot", os[0], 2'd0);
    idle(2);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    idle(1);
    chk("postrst_b", ow[0][1], 2'd1);

    // Biased random traffic
    for (int k = 0; k < 600; k++) begin
      sel = int'($urandom_range(0, 1));
      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      if (in_frame[sel] && n[sel] == 0) sy = ($urandom_range(0, 7) != 0);
      else if (!in_frame[sel])          sy = ($urandom_range(0, 2) == 0);
      else                              sy = ($urandom_range(0, 29) == 0);
      dn  = $urandom_range(0, 1) == 1;
      step(sel, r, iv, sy, dn);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
